xyolo_vwrite_packer: RTL

//  Write-back serializer for the xyolo vector datapath, generalised over channel count and output precision.
//  Per row: reads N_CH parallel vwrite memories at one internal address, saturates and packs them, streams words on a databus master.

---
 rtl/xyolo_vwrite_packer_if.sv | 14 +
 rtl/xyolo_vwrite_packer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/xyolo_vwrite_packer_if.sv
// rtl/xyolo_vwrite_packer_if.sv - databus write-request channel between the packer and the stage merge
interface xyolo_vwrite_packer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  valid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  ready;

  modport master (output valid, addr, wdata, wstrb, input ready);
  modport slave  (input valid, addr, wdata, wstrb, output ready);
endinterface

// File: rtl/xyolo_vwrite_packer.sv
// rtl/xyolo_vwrite_packer.sv - reads N_CH vwrite channels per row, saturates/packs them and streams words on the databus
module xyolo_vwrite_packer #(
  parameter int DATA_W  = 32,
  parameter int N_CH    = 16,
  parameter int ADDR_W  = 32,
  parameter int VADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  output logic                     done,
  input  logic [ADDR_W-1:0]        cfg_ext_addr,
  input  logic [VADDR_W-1:0]       cfg_int_addr,
  input  logic [VADDR_W-1:0]       cfg_iter,
  input  logic [ADDR_W-1:0]        cfg_incr,
  input  logic [1:0]               cfg_mode,
  output logic                     mem_en,
  output logic [VADDR_W-1:0]       mem_addr,
  input  logic [N_CH*DATA_W-1:0]   mem_rdata,
  xyolo_vwrite_packer_if.master    databus
);

  localparam int WW = $clog2(N_CH);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_WR, S_FIN} state_t;
  state_t state, state_nx;

  logic [VADDR_W-1:0]      int_addr_q, iter_q, row_q;
  logic [ADDR_W-1:0]       incr_q, row_base_q, addr_q;
  logic [1:0]              mode_q;
  logic [WW-1:0]           word_q, last_word;
  logic [N_CH*DATA_W-1:0]  row_buf;
  logic                    done_q;
  logic                    last_row;
  logic [DATA_W-1:0]       ch [N_CH];
  logic [DATA_W-1:0]       packed_word;
  logic [WW-1:0]           i1, i2;

  function automatic logic [15:0] sat16(input logic [31:0] v);
    if (!v[31] && (|v[30:15]))     return 16'h7fff;
    else if (v[31] && !(&v[30:15])) return 16'h8000;
    else                            return v[15:0];
  endfunction

  function automatic logic [7:0] sat8(input logic [31:0] v);
    if (!v[31] && (|v[30:7]))      return 8'h7f;
    else if (v[31] && !(&v[30:7])) return 8'h80;
    else                           return v[7:0];
  endfunction

  always_comb begin
    last_word = WW'(N_CH - 1);
    case (mode_q)
      2'd1:    last_word = WW'(N_CH / 2 - 1);
      2'd2:    last_word = WW'(N_CH / 4 - 1);
      default: last_word = WW'(N_CH - 1);
    endcase
  end

  assign last_row = (row_q == iter_q - VADDR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (run) state_nx = (cfg_iter == '0) ? S_FIN : S_RD;
      S_RD:   state_nx = S_LAT;
      S_LAT:  state_nx = S_WR;
      S_WR:   if (databus.ready && word_q == last_word) state_nx = last_row ? S_FIN : S_RD;
      S_FIN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Channel 0 sits in the MSBs of the memory word.
  always_comb begin
    for (int i = 0; i < N_CH; i++) ch[i] = row_buf[(N_CH-1-i)*DATA_W +: DATA_W];
  end

  always_comb begin
    i1 = word_q << 1;
    i2 = word_q << 2;
    case (mode_q)
      2'd1:    packed_word = {sat16(ch[i1]), sat16(ch[i1 | WW'(1)])};
      2'd2:    packed_word = {sat8(ch[i2]), sat8(ch[i2 | WW'(1)]),
                              sat8(ch[i2 | WW'(2)]), sat8(ch[i2 | WW'(3)])};
      default: packed_word = ch[word_q];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_addr_q <= '0;
      iter_q     <= '0;
      incr_q     <= '0;
      mode_q     <= '0;
      row_q      <= '0;
      word_q     <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      row_buf    <= '0;
      done_q     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (run) begin
          int_addr_q <= cfg_int_addr;
          iter_q     <= cfg_iter;
          incr_q     <= cfg_incr;
          mode_q     <= (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
          row_q      <= '0;
          word_q     <= '0;
          row_base_q <= cfg_ext_addr;
          done_q     <= 1'b0;
        end
        S_LAT: begin
          row_buf <= mem_rdata;
          word_q  <= '0;
          addr_q  <= row_base_q;
        end
        // row_base_q tracks ext_addr + row*incr so no multiplier is needed.
        S_WR: if (databus.ready) begin
          word_q <= word_q + WW'(1);
          addr_q <= addr_q + ADDR_W'(4);
          if (word_q == last_word) begin
            row_q      <= row_q + VADDR_W'(1);
            row_base_q <= row_base_q + incr_q;
          end
        end
        S_FIN: done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign done          = done_q;
  assign mem_en        = (state == S_RD);
  assign mem_addr      = mem_en ? (int_addr_q + row_q) : '0;
  assign databus.valid = (state == S_WR);
  assign databus.addr  = addr_q;
  assign databus.wdata = databus.valid ? packed_word : '0;
  assign databus.wstrb = databus.valid ? '1 : '0;

endmodule
